// File: rtl/regfile_2w2r_clr_if.sv
// Register-file access bundle: two read ports, two write ports and the busy flag.
//   master: drives read addresses and write enables/addresses/data; receives
//           rdata1/rdata2 and busy.
//   slave : the register file side.
interface regfile_2w2r_clr_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              we_a;
    logic [ADDR_W-1:0] rd_a;
    logic [DATA_W-1:0] wd_a;
    logic              we_b;
    logic [ADDR_W-1:0] rd_b;
    logic [DATA_W-1:0] wd_b;
    logic              busy;

    modport master (
        output rs1, rs2, we_a, rd_a, wd_a, we_b, rd_b, wd_b,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  rs1, rs2, we_a, rd_a, wd_a, we_b, rd_b, wd_b,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/regfile_2w2r_clr.sv
// 2-write / 2-read register file with sequenced clear after reset.
//   clk : single clock, all state updates on the rising edge
//   rst : synchronous active-high reset; (re)starts the clear sequence
//   bus : regfile_2w2r_clr_if.slave
//         rs1/rs2 -> rdata1/rdata2 combinational reads,
//         we_a/rd_a/wd_a and we_b/rd_b/wd_b writes (port B wins on same address),
//         busy = 1 while the clear sequence runs (ports ignored meanwhile).
// Optional hardwired-zero entry 0 (ZERO_REG) and same-cycle write bypass (BYPASS).
module regfile_2w2r_clr #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input logic              clk,
    input logic              rst,
    regfile_2w2r_clr_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nx;
    idx_t              clr_idx, clr_idx_nx;
    logic              busy_q, busy_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_a, wr_b;

    // A write commits only to an in-range address that is not the hardwired zero.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // wr_a already excludes the case where port B targets the same entry,
    // so at most one port writes any given entry per cycle.
    always_comb begin
        wr_b = (state == READY) && bus.we_b && writable(bus.rd_b);
        wr_a = (state == READY) && bus.we_a && writable(bus.rd_a) &&
               !(wr_b && (bus.rd_b == bus.rd_a));
    end

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        busy_nx    = busy_q;
        case (state)
            CLEAR: begin
                clr_idx_nx = clr_idx + idx_t'(1);
                if (clr_idx == idx_t'(DEPTH - 1)) begin
                    state_nx   = READY;
                    busy_nx    = 1'b0;
                    clr_idx_nx = '0;
                end
            end
            READY:   ;
            default: begin
                state_nx   = CLEAR;
                clr_idx_nx = '0;
                busy_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
            busy_q  <= busy_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else begin
                if (wr_a) mem[bus.rd_a[IDX_W-1:0]] <= bus.wd_a;
                if (wr_b) mem[bus.rd_b[IDX_W-1:0]] <= bus.wd_b;
            end
        end
    end

    // Bypass only forwards writes that actually commit, B ahead of A.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if ((state == READY) && !((ZERO_REG != 0) && (a == '0))) begin
            if ((BYPASS != 0) && wr_b && (bus.rd_b == a))
                v = bus.wd_b;
            else if ((BYPASS != 0) && wr_a && (bus.rd_a == a))
                v = bus.wd_a;
            else if (32'(a) < DEPTH)
                v = mem[a[IDX_W-1:0]];
        end
        return v;
    endfunction

    assign bus.rdata1 = read_port(bus.rs1);
    assign bus.rdata2 = read_port(bus.rs2);
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_regfile_2w2r_clr.sv
module tb_regfile_2w2r_clr;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_2w2r_clr_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    regfile_2w2r_clr_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    regfile_2w2r_clr_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

    // u0: defaults, u1: no bypass, u2: 24 entries
    regfile_2w2r_clr #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    regfile_2w2r_clr #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    regfile_2w2r_clr #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.we_a = 0; bus0.we_b = 0; bus1.we_a = 0; bus1.we_b = 0;
        bus2.we_a = 0; bus2.we_b = 0;
    endtask

    task automatic test_reset();
        int d0, d1, d2;
        d0 = 0; d1 = 0; d2 = 0;
        rst = 1;
        step();
        rst = 0;
        bus0.rs1 = 5'd3; bus0.rs2 = 5'd4;
        bus0.we_a = 1; bus0.rd_a = 5'd4; bus0.wd_a = 32'hFF;
        #1;
        checks++;
        if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1 || bus2.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got %b%b%b want 111", bus0.busy, bus1.busy, bus2.busy);
        end
        checks++;
        if (bus0.rdata1 !== 32'h0 || bus0.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got %h/%h want 0/0", bus0.rdata1, bus0.rdata2);
        end
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 20) bus0.we_a = 0;
            if (n == 5) begin
                checks++;
                if (bus0.rdata2 !== 32'h0) begin
                    failures++;
                    $display("FAIL clear_no_bypass got %h want 0", bus0.rdata2);
                end
            end
            if (d0 == 0 && bus0.busy === 1'b0) d0 = n;
            if (d1 == 0 && bus1.busy === 1'b0) d1 = n;
            if (d2 == 0 && bus2.busy === 1'b0) d2 = n;
        end
        checks++;
        if (d0 != 32 || d1 != 32) begin
            failures++;
            $display("FAIL clear_len32 got %0d/%0d want 32/32", d0, d1);
        end
        checks++;
        if (d2 != 24) begin
            failures++;
            $display("FAIL clear_len24 got %0d want 24", d2);
        end
        for (int i = 0; i < 32; i++) begin
            bus0.rs1 = 5'(i); bus0.rs2 = 5'(31 - i); bus1.rs1 = 5'(i);
            bus2.rs1 = 5'(i % 24);
            #1;
            checks++;
            if (bus0.rdata1 !== 32'h0 || bus0.rdata2 !== 32'h0 ||
                bus1.rdata1 !== 32'h0 || bus2.rdata1 !== 32'h0) begin
                failures++;
                $display("FAIL cleared_entry %0d got %h %h %h %h want 0", i,
                         bus0.rdata1, bus0.rdata2, bus1.rdata1, bus2.rdata1);
            end
        end
    endtask

    task automatic test_restart();
        int d0;
        d0 = 0;
        bus0.we_a = 1; bus0.rd_a = 5'd31; bus0.wd_a = 32'h1234;
        bus0.we_b = 1; bus0.rd_b = 5'd3;  bus0.wd_b = 32'h5678;
        step();
        idle_all();
        bus0.rs1 = 5'd31; bus0.rs2 = 5'd3;
        #1;
        checks++;
        if (bus0.rdata1 !== 32'h1234 || bus0.rdata2 !== 32'h5678) begin
            failures++;
            $display("FAIL pre_restart got %h/%h want 1234/5678", bus0.rdata1, bus0.rdata2);
        end
        rst = 1; step(); rst = 0;
        for (int n = 0; n < 10; n++) step();
        rst = 1; step(); rst = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (d0 == 0 && bus0.busy === 1'b0) d0 = n;
        end
        checks++;
        if (d0 != 32) begin
            failures++;
            $display("FAIL restart_len got %0d want 32", d0);
        end
        checks++;
        if (bus0.rdata1 !== 32'h0 || bus0.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL restart_cleared got %h/%h want 0/0", bus0.rdata1, bus0.rdata2);
        end
    endtask

    task automatic test_bypass();
        bus0.we_a = 1; bus0.rd_a = 5'd5; bus0.wd_a = 32'hDEAD_BEEF; bus0.rs1 = 5'd5;
        bus1.we_a = 1; bus1.rd_a = 5'd5; bus1.wd_a = 32'hDEAD_BEEF; bus1.rs1 = 5'd5;
        #1;
        checks++;
        if (bus0.rdata1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL bypass_same_cycle got %h want deadbeef", bus0.rdata1);
        end
        checks++;
        if (bus1.rdata1 !== 32'h0) begin
            failures++;
            $display("FAIL nobypass_same_cycle got %h want 0", bus1.rdata1);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus0.rdata1 !== 32'hDEAD_BEEF || bus1.rdata1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_next_cycle got %h/%h want deadbeef", bus0.rdata1, bus1.rdata1);
        end
    endtask

    task automatic test_write_collision();
        bus0.we_a = 1; bus0.rd_a = 5'd7; bus0.wd_a = 32'd1;
        bus0.we_b = 1; bus0.rd_b = 5'd7; bus0.wd_b = 32'd2;
        bus1.we_a = 1; bus1.rd_a = 5'd7; bus1.wd_a = 32'd1;
        bus1.we_b = 1; bus1.rd_b = 5'd7; bus1.wd_b = 32'd2;
        bus0.rs1 = 5'd7; bus0.rs2 = 5'd7; bus1.rs1 = 5'd7;
        #1;
        checks++;
        if (bus0.rdata1 !== 32'd2 || bus0.rdata2 !== 32'd2) begin
            failures++;
            $display("FAIL collide_bypass got %h/%h want 2/2", bus0.rdata1, bus0.rdata2);
        end
        checks++;
        if (bus1.rdata1 !== 32'd0) begin
            failures++;
            $display("FAIL collide_nobypass got %h want 0", bus1.rdata1);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus0.rdata1 !== 32'd2 || bus1.rdata1 !== 32'd2) begin
            failures++;
            $display("FAIL collide_stored got %h/%h want 2/2", bus0.rdata1, bus1.rdata1);
        end
        step();
        checks++;
        if (bus0.rdata2 !== 32'd2) begin
            failures++;
            $display("FAIL collide_later got %h want 2", bus0.rdata2);
        end
    endtask

    task automatic test_zero_reg();
        bus0.we_a = 1; bus0.rd_a = 5'd0; bus0.wd_a = 32'hFFFF_FFFF;
        bus1.we_b = 1; bus1.rd_b = 5'd0; bus1.wd_b = 32'hFFFF_FFFF;
        bus0.rs1 = 5'd0; bus0.rs2 = 5'd0; bus1.rs1 = 5'd0;
        #1;
        checks++;
        if (bus0.rdata1 !== 32'h0 || bus0.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL zero_same_cycle got %h/%h want 0/0", bus0.rdata1, bus0.rdata2);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (bus0.rdata1 !== 32'h0 || bus1.rdata1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_next_cycle got %h/%h want 0/0", bus0.rdata1, bus1.rdata1);
        end
    endtask

    task automatic test_out_of_range();
        bus2.we_a = 1; bus2.rd_a = 5'd23; bus2.wd_a = 32'h55;
        bus2.we_b = 1; bus2.rd_b = 5'd30; bus2.wd_b = 32'd9;
        bus2.rs1 = 5'd30; bus2.rs2 = 5'd23;
        #1;
        checks++;
        if (bus2.rdata1 !== 32'h0 || bus2.rdata2 !== 32'h55) begin
            failures++;
            $display("FAIL oor_bypass got %h/%h want 0/55", bus2.rdata1, bus2.rdata2);
        end
        step();
        idle_all();
        for (int i = 0; i < 24; i++) begin
            bus2.rs1 = 5'(i);
            #1;
            checks++;
            if (bus2.rdata1 !== ((i == 23) ? 32'h55 : 32'h0)) begin
                failures++;
                $display("FAIL oor_entry %0d got %h want %h", i, bus2.rdata1,
                         (i == 23) ? 32'h55 : 32'h0);
            end
        end
        bus2.rs1 = 5'd30; bus2.rs2 = 5'd31;
        #1;
        checks++;
        if (bus2.rdata1 !== 32'h0 || bus2.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL oor_read got %h/%h want 0/0", bus2.rdata1, bus2.rdata2);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            bus0.we_a = 1; bus0.rd_a = 5'(10 + i); bus0.wd_a = 32'hA0 + 32'(i);
            bus0.we_b = 1; bus0.rd_b = 5'(20 + i); bus0.wd_b = 32'hB0 + 32'(i);
            bus0.rs1 = 5'(10 + i); bus0.rs2 = 5'(20 + i);
            #1;
            checks++;
            if (bus0.rdata1 !== 32'hA0 + 32'(i) || bus0.rdata2 !== 32'hB0 + 32'(i)) begin
                failures++;
                $display("FAIL b2b_bypass %0d got %h/%h want %h/%h", i, bus0.rdata1,
                         bus0.rdata2, 32'hA0 + 32'(i), 32'hB0 + 32'(i));
            end
            step();
        end
        idle_all();
        for (int i = 0; i < 4; i++) begin
            bus0.rs1 = 5'(10 + i); bus0.rs2 = 5'(20 + i);
            #1;
            checks++;
            if (bus0.rdata1 !== 32'hA0 + 32'(i) || bus0.rdata2 !== 32'hB0 + 32'(i)) begin
                failures++;
                $display("FAIL b2b_stored %0d got %h/%h want %h/%h", i, bus0.rdata1,
                         bus0.rdata2, 32'hA0 + 32'(i), 32'hB0 + 32'(i));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 0;
        bus0.rs1 = 0; bus0.rs2 = 0; bus0.rd_a = 0; bus0.wd_a = 0; bus0.rd_b = 0; bus0.wd_b = 0;
        bus1.rs1 = 0; bus1.rs2 = 0; bus1.rd_a = 0; bus1.wd_a = 0; bus1.rd_b = 0; bus1.wd_b = 0;
        bus2.rs1 = 0; bus2.rs2 = 0; bus2.rd_a = 0; bus2.wd_a = 0; bus2.rd_b = 0; bus2.wd_b = 0;
        idle_all();
        #2;
        test_reset();
        test_restart();
        test_bypass();
        test_write_collision();
        test_zero_reg();
        test_out_of_range();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
